operand_entry: RTL and testbench

// - Front end of the calculator: turns bouncy raw buttons and a keypad digit into a BCD operand in_val, a sign and a clean enter_button strobe.
// - in_val and enter_button feed the state controller, which captures the operand on the rising edge of enter_button.
// - Owns debouncing, digit accumulation, sign toggle and clear. Holds in_val stable across the enter strobe, then starts a fresh entry.

---
 rtl/calc_pkg.sv | 19 +
 rtl/button_debouncer.sv | 61 ++++++
 rtl/operand_entry.sv | 137 +++++++++++++
 tb/tb_operand_entry.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared calculator definitions: operand geometry, entry FSM encoding and
// a BCD code check used by the operand entry front end.
package calc_pkg;

    localparam int BCD_DIGITS = 10;
    localparam int VAL_W      = 4 * BCD_DIGITS;

    // One-hot entry FSM encoding; each bit is directly a flop output.
    typedef enum logic [2:0] {
        ENT_IDLE   = 3'b001,
        ENT_COMMIT = 3'b010,
        ENT_FLUSH  = 3'b100
    } ent_state_e;

    function automatic logic is_bcd_digit(input logic [3:0] code);
        return (code <= 4'd9);
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchronizer, stability counter and rising-edge press pulse for
// one bouncy push button. Releases are accepted silently.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input  logic clk,
    input  logic reset_button,
    input  logic raw_i,
    output logic rise_o
);

    logic             sync1_q, sync2_q;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rise_q, rise_d;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    always_ff @(posedge clk or posedge reset_button) begin
        if (reset_button) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
        end
    end

    // Any return to the accepted level reloads the counter, so a
    // two-level input restarts its count on every bounce.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        rise_d   = 1'b0;
        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d    = '0;
            stable_d = sync2_q;
            rise_d   = sync2_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset_button) begin
        if (reset_button) begin
            stable_q <= 1'b0;
            cnt_q    <= '0;
            rise_q   <= 1'b0;
        end else begin
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            rise_q   <= rise_d;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/operand_entry.sv
// Calculator front end: debounced buttons build a signed BCD operand and a
// clean enter strobe; the operand is frozen during the strobe, then flushed.
module operand_entry
    import calc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19,
    parameter int ENTER_HOLD      = 4,
    parameter int MAX_DIGITS      = BCD_DIGITS
) (
    input  logic             clk,
    input  logic             reset_button,
    input  logic             key_raw,
    input  logic [3:0]       key_digit,
    input  logic             enter_raw,
    input  logic             neg_raw,
    input  logic             clr_raw,
    output logic [VAL_W-1:0] in_val,
    output logic             in_sign,
    output logic             enter_button,
    output logic [3:0]       digit_count,
    output logic             overflow,
    output logic [2:0]       dbg_state
);

    localparam int              HOLD_W    = $clog2(ENTER_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(ENTER_HOLD - 1);
    localparam logic [3:0]      MAX_CNT   = 4'(MAX_DIGITS);

    logic key_ev, enter_ev, neg_ev, clr_ev;

    ent_state_e        state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [VAL_W-1:0]  val_q, val_d;
    logic              sign_q, sign_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              ovf_q, ovf_d;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_key (
        .clk(clk), .reset_button(reset_button), .raw_i(key_raw), .rise_o(key_ev));
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_enter (
        .clk(clk), .reset_button(reset_button), .raw_i(enter_raw), .rise_o(enter_ev));
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_neg (
        .clk(clk), .reset_button(reset_button), .raw_i(neg_raw), .rise_o(neg_ev));
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_clr (
        .clk(clk), .reset_button(reset_button), .raw_i(clr_raw), .rise_o(clr_ev));

    always_ff @(posedge clk or posedge reset_button) begin
        if (reset_button) begin
            state_q <= ENT_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A clear in the same cycle as enter wins and swallows the enter.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ENT_IDLE:   if (enter_ev && !clr_ev) state_d = ENT_COMMIT;
            ENT_COMMIT: if (hold_q == HOLD_LAST) state_d = ENT_FLUSH;
            ENT_FLUSH:  state_d = ENT_IDLE;
            default:    state_d = ENT_IDLE;
        endcase
    end

    always_comb begin
        enter_button = (state_q == ENT_COMMIT);
        dbg_state    = state_q;
    end

    always_comb begin
        val_d  = val_q;
        sign_d = sign_q;
        cnt_d  = cnt_q;
        ovf_d  = ovf_q;
        hold_d = hold_q;
        unique case (state_q)
            ENT_IDLE: begin
                hold_d = '0;
                if (clr_ev) begin
                    val_d  = '0;
                    sign_d = 1'b0;
                    cnt_d  = '0;
                    ovf_d  = 1'b0;
                end else if (enter_ev) begin
                    // Operand stays as is; the FSM takes over.
                end else if (key_ev) begin
                    if (is_bcd_digit(key_digit)) begin
                        if (cnt_q == 4'd0 && key_digit == 4'd0) begin
                            // Leading zero carries no value.
                        end else if (cnt_q < MAX_CNT) begin
                            val_d = {val_q[VAL_W-5:0], key_digit};
                            cnt_d = cnt_q + 4'd1;
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end
                end else if (neg_ev) begin
                    sign_d = ~sign_q;
                end
            end
            ENT_COMMIT: begin
                hold_d = hold_q + 1'b1;
            end
            default: begin
                val_d  = '0;
                sign_d = 1'b0;
                cnt_d  = '0;
                ovf_d  = 1'b0;
                hold_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset_button) begin
        if (reset_button) begin
            val_q  <= '0;
            sign_q <= 1'b0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
            hold_q <= '0;
        end else begin
            val_q  <= val_d;
            sign_q <= sign_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
            hold_q <= hold_d;
        end
    end

    assign in_val      = val_q;
    assign in_sign     = sign_q;
    assign digit_count = cnt_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_operand_entry.sv
// Directed bench for operand_entry with a short debounce window.
module tb_operand_entry;

    localparam int DB   = 4;
    localparam int HOLD = 4;
    localparam int SETTLE = DB + 6;

    logic        clk;
    logic        reset_button;
    logic        key_raw;
    logic [3:0]  key_digit;
    logic        enter_raw;
    logic        neg_raw;
    logic        clr_raw;
    logic [39:0] in_val;
    logic        in_sign;
    logic        enter_button;
    logic [3:0]  digit_count;
    logic        overflow;
    logic [2:0]  dbg_state;

    int tests_run;
    int tests_failed;

    operand_entry #(
        .DEBOUNCE_CYCLES(DB),
        .CNT_W(3),
        .ENTER_HOLD(HOLD),
        .MAX_DIGITS(10)
    ) dut (
        .clk(clk),
        .reset_button(reset_button),
        .key_raw(key_raw),
        .key_digit(key_digit),
        .enter_raw(enter_raw),
        .neg_raw(neg_raw),
        .clr_raw(clr_raw),
        .in_val(in_val),
        .in_sign(in_sign),
        .enter_button(enter_button),
        .digit_count(digit_count),
        .overflow(overflow),
        .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_digit(input logic [3:0] d);
        key_digit = d;
        key_raw = 1'b1;
        wait_cycles(SETTLE);
        key_raw = 1'b0;
        wait_cycles(SETTLE);
    endtask

    task automatic press_neg();
        neg_raw = 1'b1;
        wait_cycles(SETTLE);
        neg_raw = 1'b0;
        wait_cycles(SETTLE);
    endtask

    task automatic press_clr();
        clr_raw = 1'b1;
        wait_cycles(SETTLE);
        clr_raw = 1'b0;
        wait_cycles(SETTLE);
    endtask

    task automatic test_reset();
        reset_button = 1'b1;
        wait_cycles(3);
        tests_run++;
        if (in_val !== 40'h0 || in_sign !== 1'b0 || enter_button !== 1'b0 ||
            digit_count !== 4'd0 || overflow !== 1'b0 || dbg_state !== 3'b001) begin
            tests_failed++;
            $display("FAIL reset: in_val=%h sign=%b enter=%b cnt=%0d ovf=%b st=%b required all 0, st=001",
                     in_val, in_sign, enter_button, digit_count, overflow, dbg_state);
        end
        reset_button = 1'b0;
        wait_cycles(3);
    endtask

    task automatic test_digits();
        press_digit(4'd1);
        press_digit(4'd2);
        press_digit(4'd3);
        tests_run++;
        if (in_val !== 40'h123 || digit_count !== 4'd3) begin
            tests_failed++;
            $display("FAIL digits_123: in_val=%h cnt=%0d required 123 / 3", in_val, digit_count);
        end
    endtask

    task automatic test_enter();
        int hi;
        int bad;
        hi = 0;
        bad = 0;
        enter_raw = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (enter_button === 1'b1) begin
                hi++;
                if (in_val !== 40'h123) bad++;
            end
        end
        enter_raw = 1'b0;
        wait_cycles(SETTLE);
        tests_run++;
        if (hi != HOLD) begin
            tests_failed++;
            $display("FAIL enter_width: high for %0d cycles required %0d", hi, HOLD);
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL enter_hold_val: %0d strobe cycles with in_val != 123 required 0", bad);
        end
        tests_run++;
        if (in_val !== 40'h0 || digit_count !== 4'd0 || enter_button !== 1'b0) begin
            tests_failed++;
            $display("FAIL enter_flush: in_val=%h cnt=%0d enter=%b required 0/0/0",
                     in_val, digit_count, enter_button);
        end
    endtask

    task automatic test_bounce();
        key_digit = 4'd7;
        for (int i = 0; i < 10; i++) begin
            key_raw = ~key_raw;
            wait_cycles(2);
        end
        key_raw = 1'b1;
        wait_cycles(SETTLE);
        key_raw = 1'b0;
        wait_cycles(SETTLE);
        tests_run++;
        if (in_val !== 40'h7 || digit_count !== 4'd1) begin
            tests_failed++;
            $display("FAIL bounce: in_val=%h cnt=%0d required 7 / 1", in_val, digit_count);
        end
    endtask

    task automatic test_glitch();
        key_digit = 4'd2;
        key_raw = 1'b1;
        wait_cycles(DB - 1);
        key_raw = 1'b0;
        wait_cycles(SETTLE);
        tests_run++;
        if (in_val !== 40'h7 || digit_count !== 4'd1) begin
            tests_failed++;
            $display("FAIL glitch: in_val=%h cnt=%0d required 7 / 1", in_val, digit_count);
        end
    endtask

    task automatic test_leading_zero();
        press_clr();
        press_digit(4'd0);
        press_digit(4'd0);
        tests_run++;
        if (in_val !== 40'h0 || digit_count !== 4'd0) begin
            tests_failed++;
            $display("FAIL lead_zero: in_val=%h cnt=%0d required 0 / 0", in_val, digit_count);
        end
        press_digit(4'd5);
        tests_run++;
        if (in_val !== 40'h5 || digit_count !== 4'd1) begin
            tests_failed++;
            $display("FAIL lead_zero_5: in_val=%h cnt=%0d required 5 / 1", in_val, digit_count);
        end
    endtask

    task automatic test_invalid_codes();
        for (int c = 10; c < 16; c++) press_digit(4'(c));
        tests_run++;
        if (in_val !== 40'h5 || digit_count !== 4'd1 || overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL bad_codes: in_val=%h cnt=%0d ovf=%b required 5 / 1 / 0",
                     in_val, digit_count, overflow);
        end
    endtask

    task automatic test_overflow();
        press_clr();
        for (int d = 1; d <= 10; d++) press_digit(4'(d % 10));
        tests_run++;
        if (in_val !== 40'h1234567890 || digit_count !== 4'd10 || overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL full: in_val=%h cnt=%0d ovf=%b required 1234567890 / 10 / 0",
                     in_val, digit_count, overflow);
        end
        press_digit(4'd4);
        tests_run++;
        if (in_val !== 40'h1234567890 || digit_count !== 4'd10 || overflow !== 1'b1) begin
            tests_failed++;
            $display("FAIL overflow: in_val=%h cnt=%0d ovf=%b required 1234567890 / 10 / 1",
                     in_val, digit_count, overflow);
        end
    endtask

    task automatic test_clear();
        press_neg();
        press_clr();
        tests_run++;
        if (in_val !== 40'h0 || in_sign !== 1'b0 || digit_count !== 4'd0 || overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL clear: in_val=%h sign=%b cnt=%0d ovf=%b required all 0",
                     in_val, in_sign, digit_count, overflow);
        end
    endtask

    task automatic test_sign();
        press_neg();
        press_digit(4'd8);
        tests_run++;
        if (in_sign !== 1'b1 || in_val !== 40'h8 || digit_count !== 4'd1) begin
            tests_failed++;
            $display("FAIL sign: sign=%b in_val=%h cnt=%0d required 1 / 8 / 1",
                     in_sign, in_val, digit_count);
        end
    endtask

    task automatic test_commit_drop();
        int hi;
        int bad;
        hi = 0;
        bad = 0;
        enter_raw = 1'b1;
        wait_cycles(2);
        key_digit = 4'd4;
        key_raw = 1'b1;
        neg_raw = 1'b1;
        clr_raw = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (enter_button === 1'b1) begin
                hi++;
                if (in_sign !== 1'b1 || in_val !== 40'h8) bad++;
            end
        end
        enter_raw = 1'b0;
        key_raw = 1'b0;
        neg_raw = 1'b0;
        clr_raw = 1'b0;
        wait_cycles(SETTLE);
        tests_run++;
        if (hi != HOLD || bad != 0) begin
            tests_failed++;
            $display("FAIL commit_drop_strobe: high=%0d bad=%0d required %0d / 0", hi, bad, HOLD);
        end
        tests_run++;
        if (in_val !== 40'h0 || in_sign !== 1'b0 || digit_count !== 4'd0 || overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL commit_drop_after: in_val=%h sign=%b cnt=%0d ovf=%b required all 0",
                     in_val, in_sign, digit_count, overflow);
        end
    endtask

    task automatic test_same_cycle();
        press_digit(4'd3);
        key_digit = 4'd5;
        key_raw = 1'b1;
        clr_raw = 1'b1;
        wait_cycles(SETTLE);
        key_raw = 1'b0;
        clr_raw = 1'b0;
        wait_cycles(SETTLE);
        tests_run++;
        if (in_val !== 40'h0 || digit_count !== 4'd0) begin
            tests_failed++;
            $display("FAIL clr_and_digit: in_val=%h cnt=%0d required 0 / 0", in_val, digit_count);
        end
    endtask

    task automatic test_reset_mid_commit();
        int late;
        late = 0;
        press_digit(4'd6);
        press_neg();
        enter_raw = 1'b1;
        for (int i = 0; i < 30 && enter_button !== 1'b1; i++) @(negedge clk);
        tests_run++;
        if (enter_button !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_commit_wait: enter_button=%b required 1 within 30 cycles", enter_button);
        end
        @(posedge clk);
        #2;
        reset_button = 1'b1;
        #1;
        tests_run++;
        if (enter_button !== 1'b0 || in_val !== 40'h0 || in_sign !== 1'b0 ||
            digit_count !== 4'd0 || overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_commit_async: enter=%b in_val=%h sign=%b cnt=%0d ovf=%b required all 0",
                     enter_button, in_val, in_sign, digit_count, overflow);
        end
        enter_raw = 1'b0;
        wait_cycles(3);
        reset_button = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (enter_button !== 1'b0) late++;
        end
        tests_run++;
        if (late != 0) begin
            tests_failed++;
            $display("FAIL rst_commit_no_edge: enter high %0d cycles after reset required 0", late);
        end
        press_digit(4'd9);
        tests_run++;
        if (in_val !== 40'h9 || digit_count !== 4'd1) begin
            tests_failed++;
            $display("FAIL rst_commit_resume: in_val=%h cnt=%0d required 9 / 1", in_val, digit_count);
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        reset_button = 1'b0;
        key_raw = 1'b0;
        key_digit = 4'd0;
        enter_raw = 1'b0;
        neg_raw = 1'b0;
        clr_raw = 1'b0;
        @(negedge clk);
        test_reset();
        test_digits();
        test_enter();
        test_bounce();
        test_glitch();
        test_leading_zero();
        test_invalid_codes();
        test_overflow();
        test_clear();
        test_sign();
        test_commit_drop();
        test_same_cycle();
        test_reset_mid_commit();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
